// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and baud divisor helper
package uart_pkg;

    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_DEFAULT_DIV = 326;

    // Divisor for clk_hz / (baud * os), rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// rtl/uart_baud_gen_if.sv - control and tick bundle of the baud generator
interface uart_baud_gen_if #(
    parameter int DIV_W = 16
);

    logic             en;
    logic             restart;
    logic             mid;
    logic             div_load;
    logic [DIV_W-1:0] div_in;
    logic             tick_os;
    logic             tick_bit;
    logic [DIV_W-1:0] div_q;
    logic             div_err;

    modport master (
        output en, restart, mid, div_load, div_in,
        input  tick_os, tick_bit, div_q, div_err
    );

    modport slave (
        input  en, restart, mid, div_load, div_in,
        output tick_os, tick_bit, div_q, div_err
    );

endinterface

// File: rtl/uart_baud_gen_mod_counter.sv
// rtl/uart_baud_gen_mod_counter.sv - wrap counter with clear and preload
module mod_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    input  logic         preload,
    input  logic [W-1:0] preload_val,
    input  logic [W:0]   modulus,
    output logic [W-1:0] count,
    output logic         wrap
);

    logic [W-1:0] count_r;

    // modulus is one bit wider so a full power-of-two range is expressible.
    assign wrap  = inc && ({1'b0, count_r} == modulus - (W + 1)'(1));
    assign count = count_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (preload) begin
            count_r <= preload_val;
        end else if (clr) begin
            count_r <= '0;
        end else if (inc) begin
            count_r <= wrap ? '0 : count_r + W'(1);
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - baud tick generator with oversample and bit ticks
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE
) (
    input  logic            clk,
    input  logic            rst,
    uart_baud_gen_if.slave  bus
);

    localparam int              OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W:0]   OS_MOD  = (OS_W + 1)'(OVERSAMPLE);

    logic [DIV_W-1:0] div_r;
    logic             tick_os_r;
    logic             tick_bit_r;
    logic             div_err_r;
    logic [DIV_W-1:0] presc;
    logic [OS_W-1:0]  os_cnt;
    logic             presc_wrap;
    logic             os_wrap;
    logic             phase_rst;
    logic             load_ok;

    // A rejected load still realigns the phase, exactly like a valid one.
    assign phase_rst = bus.div_load | bus.restart;
    assign load_ok   = bus.div_in >= DIV_W'(2);

    mod_counter #(.W(DIV_W)) u_presc (
        .clk         (clk),
        .rst         (rst),
        .inc         (bus.en & ~phase_rst),
        .clr         (phase_rst),
        .preload     (1'b0),
        .preload_val ('0),
        .modulus     ({1'b0, div_r}),
        .count       (presc),
        .wrap        (presc_wrap)
    );

    mod_counter #(.W(OS_W)) u_os (
        .clk         (clk),
        .rst         (rst),
        .inc         (presc_wrap),
        .clr         (phase_rst),
        .preload     (bus.restart & bus.mid),
        .preload_val (OS_HALF),
        .modulus     (OS_MOD),
        .count       (os_cnt),
        .wrap        (os_wrap)
    );

    // presc_wrap is already gated by en and phase_rst, so ticks drop with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r      <= DIV_W'(DEFAULT_DIV);
            tick_os_r  <= 1'b0;
            tick_bit_r <= 1'b0;
            div_err_r  <= 1'b0;
        end else begin
            if (bus.div_load && load_ok) begin
                div_r <= bus.div_in;
            end
            div_err_r  <= bus.div_load && !load_ok;
            tick_os_r  <= presc_wrap;
            tick_bit_r <= os_wrap;
        end
    end

    assign bus.tick_os  = tick_os_r;
    assign bus.tick_bit = tick_bit_r;
    assign bus.div_q    = div_r;
    assign bus.div_err  = div_err_r;

    a_presc_range: assert property (@(posedge clk) disable iff (rst) presc < div_r);
    a_bit_phase:   assert property (@(posedge clk) disable iff (rst) tick_bit_r |-> os_cnt == '0);

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - randomized self-checking bench for uart_baud_gen
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 4;
    localparam int OS      = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_baud_gen_if #(.DIV_W(DIV_W)) bus ();

    uart_baud_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEF_DIV),
        .OVERSAMPLE  (OS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: m_n counts enabled cycles since the last phase origin.
    int m_n, m_d, m_os0;
    bit e_os, e_bit, e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_n = 0; m_d = DEF_DIV; m_os0 = 0;
        e_os = 0; e_bit = 0; e_err = 0;
    endtask

    task automatic model_step();
        e_err = 0;
        if (bus.div_load) begin
            if (int'(bus.div_in) >= 2) m_d = int'(bus.div_in);
            else e_err = 1;
        end
        if (bus.div_load || bus.restart) begin
            m_n   = 0;
            m_os0 = (bus.restart && bus.mid) ? OS / 2 : 0;
            e_os  = 0; e_bit = 0;
        end else if (bus.en) begin
            m_n++;
            e_os  = (m_n % m_d) == 0;
            e_bit = e_os && (((m_n / m_d) + m_os0) % OS == 0);
        end else begin
            e_os = 0; e_bit = 0;
        end
    endtask

    task automatic check_outputs();
        check("tick_os",  bus.tick_os,  e_os);
        check("tick_bit", bus.tick_bit, e_bit);
        check("div_q",    bus.div_q,    m_d);
        check("div_err",  bus.div_err,  e_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit en, input bit restart, input bit mid,
                         input bit load, input int din);
        bus.en = en; bus.restart = restart; bus.mid = mid;
        bus.div_load = load; bus.div_in = DIV_W'(din);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int guard;
        longint a, b, q, r;
        int ck, bd, os_sel;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Free run from reset
        drive(1, 0, 0, 0, 0);
        steps(40);

        // Mid-bit restart
        drive(1, 1, 1, 0, 0);
        step();
        drive(1, 0, 0, 0, 0);
        steps(40);

        // Hold with en low when the prescaler sits at 2
        guard = 0;
        while ((m_n % m_d) != 2 && guard < 20) begin step(); guard++; end
        check("presc2_wait", guard < 20, 1);
        drive(0, 0, 0, 0, 0);
        steps(7);
        drive(1, 0, 0, 0, 0);
        steps(40);

        // Valid runtime load
        steps(2);
        drive(1, 0, 0, 1, 6);
        step();
        drive(1, 0, 0, 0, 0);
        steps(60);

        // Back to 4, then rejected loads of 1 and 0
        drive(1, 0, 0, 1, 4);
        step();
        drive(1, 0, 0, 0, 0);
        steps(10);
        drive(1, 0, 0, 1, 1);
        step();
        drive(1, 0, 0, 0, 0);
        steps(10);
        drive(1, 0, 0, 1, 0);
        step();
        drive(1, 0, 0, 0, 0);
        steps(12);

        // Async reset while tick_os is high
        guard = 0;
        while (!e_os && guard < 20) begin step(); guard++; end
        check("tick_wait", guard < 20, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        #1 rst = 1'b0;
        steps(10);

        // Load and restart together with mid: load wins, os preloads to half
        drive(1, 1, 1, 1, 5);
        step();
        drive(1, 0, 0, 0, 0);
        steps(30);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0,
                  $urandom_range(0, 7));
            step();
        end
        drive(1, 0, 0, 0, 0);
        steps(5);

        // Divisor helper rounds to nearest
        for (int i = 0; i < 8; i++) begin
            ck     = $urandom_range(1_000_000, 100_000_000);
            bd     = $urandom_range(300, 115_200);
            os_sel = ($urandom_range(0, 1) != 0) ? 16 : 8;
            a = ck; b = longint'(bd) * os_sel;
            q = a / b; r = a % b;
            check("baud_div", baud_div(ck, bd, os_sel), 32'((2 * r >= b) ? q + 1 : q));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
